// File: rtl/imem_loader.sv
// imem_loader: turns a length-prefixed byte stream into 32-bit instruction-memory writes, holding the CPU in reset until loaded.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byteValid,
  input  logic [7:0]  byteData,
  output logic        byteReady,
  input  logic        reload,
  output logic        memWrite,
  output logic [31:0] memAddr,
  output logic [31:0] memData,
  output logic        cpuRst,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    DATA   = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK    = 3'd3,
`endif
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t LOAD_END = CHK;
`else
  localparam state_t LOAD_END = DONE;
`endif

  state_t      state_q, state_d;
  logic [15:0] hdr_q, hdr_d;
  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] idx_q, idx_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        cpu_rst_q, done_q, error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic [15:0] n_hdr;
  logic        last_word;
  assign n_hdr     = {hdr_q[15:8], byteData};
  assign last_word = (idx_q == hdr_q - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= HDR_HI;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HDR_HI: if (byteValid) state_d = HDR_LO;
      HDR_LO: begin
        if (byteValid) begin
          if ({16'd0, n_hdr} > MAX_WORDS) state_d = ERR;
          else if (n_hdr == 16'd0)        state_d = LOAD_END;
          else                            state_d = DATA;
        end
      end
      DATA: if (byteValid && cnt_q == 2'd3 && last_word) state_d = LOAD_END;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: if (byteValid) state_d = (byteData == csum_q) ? DONE : ERR;
`endif
      DONE, ERR: if (reload) state_d = HDR_HI;
      default: state_d = HDR_HI;
    endcase
  end

  always_comb begin
    byteReady   = 1'b0;
    hdr_d       = hdr_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      HDR_HI: begin
        byteReady = 1'b1;
        if (byteValid) hdr_d = {byteData, 8'h00};
      end
      HDR_LO: begin
        byteReady = 1'b1;
        if (byteValid) hdr_d = n_hdr;
      end
      DATA: begin
        byteReady = 1'b1;
        if (byteValid) begin
          shift_d = {shift_q[15:0], byteData};
          cnt_d   = cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ byteData;
`endif
          // Fourth byte completes the word: strobe it out next cycle, big-endian.
          if (cnt_q == 2'd3) begin
            mem_write_d = 1'b1;
            mem_data_d  = {shift_q, byteData};
            mem_addr_d  = {16'd0, idx_q};
            idx_d       = idx_q + 16'd1;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: byteReady = 1'b1;
`endif
      DONE, ERR: begin
        if (reload) begin
          idx_d  = 16'd0;
          cnt_d  = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = 8'd0;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_q       <= 16'd0;
      shift_q     <= 24'd0;
      cnt_q       <= 2'd0;
      idx_q       <= 16'd0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_data_q  <= 32'd0;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= 8'd0;
`endif
    end else begin
      hdr_q       <= hdr_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      cpu_rst_q   <= (state_q != DONE);
      done_q      <= (state_q == DONE);
      error_q     <= (state_q == ERR);
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign memWrite = mem_write_q;
  assign memAddr  = mem_addr_q;
  assign memData  = mem_data_q;
  assign cpuRst   = cpu_rst_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: MAX_WORDS, default 256, instruction-memory depth in 32-bit words; legal header counts are 0..MAX_WORDS.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 byteValid  input  1  byteData holds a valid stream byte.
REQ-005 byteData  input  8  load-stream byte.
REQ-006 byteReady  output  1  loader accepts a byte this cycle; a byte transfers when byteValid & byteReady.
REQ-007 reload  input  1  single-cycle request to restart loading; honoured only in DONE or ERR.
REQ-008 memWrite  output  1  single-cycle instruction-memory write strobe.
REQ-009 memAddr  output  32  word index written, matching the CPU's PC-increments-by-one addressing.
REQ-010 memData  output  32  instruction word written.
REQ-011 cpuRst  output  1  holds the processor in reset while the loader is not in DONE.
REQ-012 done  output  1  load completed successfully.
REQ-013 error  output  1  load aborted.

Function
REQ-014 The stream format SHALL be: 16-bit word count N, big-endian (HDR_HI, then HDR_LO), followed by N words of 4 bytes each, most-significant byte first.
REQ-015 The FSM SHALL have states HDR_HI, HDR_LO, DATA, CHK, DONE and ERR; CHK exists only under REQ-028.
REQ-016 byteReady SHALL be 1 in HDR_HI, HDR_LO, DATA and CHK, and 0 in DONE and ERR; no back-pressure is applied during writes.
REQ-017 HDR_LO transfer: if N > MAX_WORDS, go to ERR; else if N = 0, go to CHK or DONE; else go to DATA.
REQ-018 DATA SHALL assemble bytes into a 32-bit shift register, using a 2-bit byte counter that wraps 3 -> 0.
REQ-019 On the transfer of the 4th byte of a word, memWrite SHALL be 1 on the next cycle, with memData = the assembled word and memAddr = the current word index.
REQ-020 After each write the word index SHALL increment by 1, starting from 0.
REQ-021 After word N-1 is written, the FSM SHALL enter CHK (macro defined) or DONE (macro undefined) on the same edge that issues the write strobe.
REQ-022 Cycles with byteValid = 0 SHALL not change any state, counter or partial word; gaps between bytes are unlimited.
REQ-023 cpuRst SHALL be 0 only in DONE; done = (state == DONE); error = (state == ERR); all three are registered.
REQ-024 reload in DONE or ERR SHALL clear the word index, byte counter and checksum, enter HDR_HI, and raise cpuRst on the next cycle.
REQ-025 reload in any other state SHALL be ignored.

Reset
REQ-026 rst SHALL have priority over every other input, including a same-cycle transfer or reload.
REQ-027 On rst, the FSM SHALL enter HDR_HI and the outputs SHALL take these values: memWrite = 0, memAddr = 0, memData = 0, cpuRst = 1, done = 0, error = 0; the word index, byte counter, header register and checksum SHALL be cleared. A partially loaded image is abandoned; previously written memory contents are not erased.

Configuration
REQ-028 IMEM_LOADER_CHECKSUM_EN defined: the loader SHALL keep a running XOR of all data bytes (header excluded), and after the last word it SHALL accept one checksum byte in CHK.
REQ-029 With the macro defined, a checksum byte equal to the running XOR SHALL lead to DONE; a mismatch SHALL lead to ERR, with cpuRst held at 1.
REQ-030 IMEM_LOADER_CHECKSUM_EN undefined: the CHK state and checksum logic SHALL be absent, and the load SHALL complete directly to DONE.

Verification
REQ-031 Macro off, stream 00 02 | 20 08 00 05 | 01 09 50 20 -> two memWrite pulses: (addr 0, 0x20080005) and (addr 1, 0x01095020); then done = 1 and cpuRst = 0 one cycle after the second strobe.
REQ-032 Same stream with byteValid low on alternate cycles -> identical writes and final state; byteReady stays 1 until DONE.
REQ-033 Header 01 01 with MAX_WORDS = 256 -> error = 1 next cycle, no memWrite, byteReady = 0, cpuRst = 1.
REQ-034 Macro on, stream 00 01 | 12 34 56 78 | 08 -> one write (addr 0, 0x12345678), then done = 1; with checksum byte 09 instead -> error = 1 and cpuRst = 1.
REQ-035 rst asserted after 2 data bytes of the first word, then a full 1-word stream -> exactly one write at addr 0 carrying the new word; a reload pulse in DONE -> cpuRst = 1 and the state returns to HDR_HI.
